// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared
// Montgomery multiplier; converts the result back to plain form at the end.
module mont_exp_ctrl #(
   parameter int WIDTH     = 512,
   parameter int EXP_WIDTH = 512,
   parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic [WIDTH-1:0]     base_mont_in,
   input  logic [WIDTH-1:0]     one_mont_in,
   input  logic [EXP_WIDTH-1:0] exp_in,
   input  logic [LEN_W-1:0]     exp_len_in,
   output logic                 mul_start_out,
   output logic [WIDTH-1:0]     mul_a_out,
   output logic [WIDTH-1:0]     mul_b_out,
   input  logic                 mul_done_in,
   input  logic [WIDTH-1:0]     mul_result_in,
   output logic                 busy_out,
   output logic                 done_out,
   output logic [WIDTH-1:0]     result_out
);

   localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SQ_REQ,
      SQ_WAIT,
      ML_REQ,
      ML_WAIT,
      CV_REQ,
      CV_WAIT,
      DONE
   } state_t;

   state_t               state;
   state_t               next_state;

   logic [WIDTH-1:0]     acc;
   logic [WIDTH-1:0]     base;
   logic [EXP_WIDTH-1:0] expo;
   logic [IDX_W-1:0]     idx;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic [WIDTH-1:0]     result;

   logic [LEN_W-1:0]     len_sat;
   logic [IDX_W-1:0]     idx_init;
   logic                 accept;
   logic                 bit_set;
   logic                 idx_zero;
   logic                 wait_done;
   logic [WIDTH-1:0]     nxt_acc;
   logic                 dec_idx;
   logic                 load_ops;
   logic [WIDTH-1:0]     nxt_b;

   // Clamp the requested length and derive the starting bit index
   always_comb begin
      len_sat = exp_len_in;
      if (exp_len_in > LEN_W'(EXP_WIDTH)) begin
         len_sat = LEN_W'(EXP_WIDTH);
      end
      idx_init  = IDX_W'(len_sat - LEN_W'(1));
      accept    = (state == IDLE) && start_in;
      bit_set   = expo[idx];
      idx_zero  = (idx == '0);
      wait_done = mul_done_in &&
                  ((state == SQ_WAIT) || (state == ML_WAIT));
   end

   // State register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic for the square/multiply/convert sequence
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_in) begin
               if (len_sat != '0) begin
                  next_state = SQ_REQ;
               end else begin
                  next_state = CV_REQ;
               end
            end
         end
         SQ_REQ: begin
            next_state = SQ_WAIT;
         end
         SQ_WAIT: begin
            if (mul_done_in) begin
               if (bit_set) begin
                  next_state = ML_REQ;
               end else if (idx_zero) begin
                  next_state = CV_REQ;
               end else begin
                  next_state = SQ_REQ;
               end
            end
         end
         ML_REQ: begin
            next_state = ML_WAIT;
         end
         ML_WAIT: begin
            if (mul_done_in) begin
               if (idx_zero) begin
                  next_state = CV_REQ;
               end else begin
                  next_state = SQ_REQ;
               end
            end
         end
         CV_REQ: begin
            next_state = CV_WAIT;
         end
         CV_WAIT: begin
            if (mul_done_in) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      mul_start_out = (state == SQ_REQ) ||
                      (state == ML_REQ) ||
                      (state == CV_REQ);
      busy_out      = (state != IDLE) && (state != DONE);
      done_out      = (state == DONE);
      mul_a_out     = op_a;
      mul_b_out     = op_b;
      result_out    = result;
   end

   // Accumulator value after this edge and operands for the next request
   always_comb begin
      nxt_acc = acc;
      if (accept) begin
         nxt_acc = one_mont_in;
      end else if (wait_done) begin
         nxt_acc = mul_result_in;
      end
      dec_idx  = wait_done && (next_state == SQ_REQ);
      load_ops = (next_state == SQ_REQ) ||
                 (next_state == ML_REQ) ||
                 (next_state == CV_REQ);
      case (next_state)
         SQ_REQ:  nxt_b = nxt_acc;
         ML_REQ:  nxt_b = base;
         default: nxt_b = WIDTH'(1);
      endcase
   end

   // Datapath registers: operands, exponent state, accumulator, result
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         acc    <= '0;
         base   <= '0;
         expo   <= '0;
         idx    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         result <= '0;
      end else begin
         acc <= nxt_acc;
         if (accept) begin
            base <= base_mont_in;
            expo <= exp_in;
            idx  <= idx_init;
         end else if (dec_idx) begin
            idx <= idx - IDX_W'(1);
         end
         if (load_ops) begin
            op_a <= nxt_acc;
            op_b <= nxt_b;
         end
         if ((state == CV_WAIT) && mul_done_in) begin
            result <= mul_result_in;
         end
      end
   end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: a Montgomery multiplier model with
// configurable latency and a plain modular-power reference.
module tb_mont_exp_ctrl;

   localparam int W  = 8;
   localparam int EW = 8;
   localparam int LW = $clog2(EW + 1);

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          start_in = 1'b0;
   logic [W-1:0]  base_mont_in = '0;
   logic [W-1:0]  one_mont_in = '0;
   logic [EW-1:0] exp_in = '0;
   logic [LW-1:0] exp_len_in = '0;
   logic          mul_start_out;
   logic [W-1:0]  mul_a_out;
   logic [W-1:0]  mul_b_out;
   logic          mul_done_in;
   logic [W-1:0]  mul_result_in;
   logic          busy_out;
   logic          done_out;
   logic [W-1:0]  result_out;

   int checks = 0;
   int failures = 0;
   int nmod = 13;
   int rinv = 3;
   int lat_cfg = 3;
   int op_count = 0;
   int lat_sum = 0;
   int stab_err = 0;
   int inj_req = 0;
   int inj_ack = 0;
   int stale_req = 0;
   int stale_ack = 0;
   int prev_res = 0;
   int op_a[$];
   int op_b[$];

   mont_exp_ctrl #(
      .WIDTH(W),
      .EXP_WIDTH(EW),
      .LEN_W(LW)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .start_in(start_in),
      .base_mont_in(base_mont_in),
      .one_mont_in(one_mont_in),
      .exp_in(exp_in),
      .exp_len_in(exp_len_in),
      .mul_start_out(mul_start_out),
      .mul_a_out(mul_a_out),
      .mul_b_out(mul_b_out),
      .mul_done_in(mul_done_in),
      .mul_result_in(mul_result_in),
      .busy_out(busy_out),
      .done_out(done_out),
      .result_out(result_out)
   );

   always #5 clk_in = ~clk_in;

   // Multiplier model: a*b*R^-1 mod N, done pulse L cycles after start
   initial begin : mul_model
      int pend;
      int lat;
      logic [W-1:0] pa;
      logic [W-1:0] pb;
      logic [W-1:0] pres;
      pend = 0;
      pa = '0;
      pb = '0;
      pres = '0;
      mul_done_in = 1'b0;
      mul_result_in = '0;
      forever begin
         @(negedge clk_in);
         mul_done_in = 1'b0;
         if (!rst_in) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               if (mul_a_out !== pa || mul_b_out !== pb) stab_err++;
               pend--;
               if (pend == 0) begin
                  mul_done_in = 1'b1;
                  mul_result_in = pres;
               end
            end
            if (stale_req != stale_ack) begin
               stale_ack = stale_req;
               mul_done_in = 1'b1;
               mul_result_in = 8'hEE;
            end
            if (mul_start_out === 1'b1) begin
               if (pend > 0) stab_err++;
               pa = mul_a_out;
               pb = mul_b_out;
               pres = W'((int'(pa) * int'(pb) * rinv) % nmod);
               lat = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
               pend = lat;
               op_count++;
               lat_sum += 1 + lat;
               op_a.push_back(int'(pa));
               op_b.push_back(int'(pb));
               if (inj_req != inj_ack) begin
                  inj_ack = inj_req;
                  mul_done_in = 1'b1;
                  mul_result_in = 8'hEE;
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
      end
   endtask

   function automatic int rinv_of(input int n);
      int r;
      r = 0;
      for (int i = 1; i < n; i++) begin
         if (r == 0 && ((256 * i) % n) == 1) r = i;
      end
      return r;
   endfunction

   // One exponentiation: drives start at the current negedge
   task automatic run(input int b, input int e, input int len,
                      input int lat, input bit poke, input bit inj);
      int len_eff;
      int e_eff;
      int k;
      int exp_res;
      int n;
      int ops0;
      int lat0;
      int stab0;
      int exp_n;
      bit hold_ok;
      len_eff = (len > EW) ? EW : len;
      e_eff = e & ((1 << len_eff) - 1);
      k = len_eff + $countones(e_eff) + 1;
      exp_res = 1 % nmod;
      for (int j = 0; j < e_eff; j++) exp_res = (exp_res * b) % nmod;
      lat_cfg = lat;
      ops0 = op_count;
      lat0 = lat_sum;
      stab0 = stab_err;
      if (inj) inj_req++;
      base_mont_in = W'((b * 256) % nmod);
      one_mont_in = W'(256 % nmod);
      exp_in = EW'(e);
      exp_len_in = LW'(len);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      n = 0;
      hold_ok = 1'b1;
      chk("busy_after_start", 32'(busy_out), 1);
      while (done_out !== 1'b1 && n < 2000) begin
         if (int'(result_out) != prev_res) hold_ok = 1'b0;
         if (poke && n == 3) begin
            start_in = 1'b1;
            base_mont_in = ~base_mont_in;
            one_mont_in = one_mont_in + 8'd1;
            exp_in = ~exp_in;
            exp_len_in = LW'(EW);
         end else begin
            start_in = 1'b0;
         end
         @(negedge clk_in);
         n++;
      end
      start_in = 1'b0;
      exp_n = (lat > 0) ? k * (1 + lat) : lat_sum - lat0;
      chk("no_timeout", 32'(n < 2000), 1);
      chk("done_cycle", n + 1, exp_n + 1);
      chk("result", 32'(result_out), exp_res);
      chk("op_count", op_count - ops0, k);
      chk("busy_in_done", 32'(busy_out), 0);
      chk("result_held", 32'(hold_ok), 1);
      chk("operand_stable", stab_err - stab0, 0);
      chk("first_a_is_one", op_a[ops0], 256 % nmod);
      chk("convert_b_is_1", op_b[op_b.size() - 1], 1);
      if (len_eff == 0) chk("len0_b", op_b[ops0], 1);
      @(negedge clk_in);
      chk("done_one_cycle", 32'(done_out), 0);
      prev_res = exp_res;
   endtask

   initial begin : main
      int ops_r;
      #1;
      chk("rst_busy", 32'(busy_out), 0);
      chk("rst_done", 32'(done_out), 0);
      chk("rst_mul_start", 32'(mul_start_out), 0);
      chk("rst_result", 32'(result_out), 0);
      chk("rst_mul_a", 32'(mul_a_out), 0);
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);

      nmod = 13;
      rinv = rinv_of(13);
      chk("rinv13", rinv, 3);
      run(2, 5, 3, 3, 1'b0, 1'b0);
      run(2, 15, 4, 3, 1'b1, 1'b0);
      run(2, 15, 4, 1, 1'b0, 1'b1);
      run(2, 8'hA5, 0, 2, 1'b0, 1'b0);
      run(7, 8'hC3, 12, 2, 1'b0, 1'b1);

      lat_cfg = 3;
      base_mont_in = W'((2 * 256) % 13);
      one_mont_in = W'(256 % 13);
      exp_in = EW'(15);
      exp_len_in = LW'(4);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy_out), 0);
      chk("midrst_mul_start", 32'(mul_start_out), 0);
      chk("midrst_result", 32'(result_out), 0);
      chk("midrst_done", 32'(done_out), 0);
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      ops_r = op_count;
      stale_req++;
      repeat (3) @(negedge clk_in);
      chk("stale_busy", 32'(busy_out), 0);
      chk("stale_done", 32'(done_out), 0);
      chk("stale_no_op", op_count - ops_r, 0);
      chk("stale_result", 32'(result_out), 0);
      prev_res = 0;
      run(2, 5, 3, 3, 1'b0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         nmod = 2 * int'($urandom_range(1, 127)) + 1;
         rinv = rinv_of(nmod);
         run(int'($urandom_range(0, nmod - 1)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 10)), 0, (t % 5) == 0, (t % 3) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
